// File: rtl/snake_move_sched.sv
// Movement scheduler: paces snake moves, commits heading on each tick,
// and tracks score and speed level from eaten food.
module snake_move_sched #(
    parameter int unsigned TICK_BASE      = 12500000,
    parameter int unsigned TICK_STEP      = 1000000,
    parameter int unsigned TICK_MIN       = 2500000,
    parameter int unsigned FOOD_PER_LEVEL = 5,
    parameter int unsigned LEVEL_MAX      = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] game_status,
    input  logic       key1_press,
    input  logic       key2_press,
    input  logic       key3_press,
    input  logic       key4_press,
    input  logic       eat_food,
    output logic       move_tick,
    output logic [1:0] direction,
    output logic [7:0] score,
    output logic [3:0] level
);

    typedef enum logic [1:0] {
        ST_RESTART = 2'b00,
        ST_START   = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } status_e;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [31:0] BASE = 32'(TICK_BASE);
    localparam logic [31:0] STEP = 32'(TICK_STEP);
    localparam logic [31:0] MINP = 32'(TICK_MIN);
    localparam logic [31:0] HEAD =
        (TICK_BASE > TICK_MIN) ? 32'(TICK_BASE - TICK_MIN) : 32'd0;
    localparam logic [31:0] FPL  = 32'(FOOD_PER_LEVEL);
    localparam logic [3:0]  LMAX = 4'(LEVEL_MAX);

    status_e     st;
    logic        tick_q, tick_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  pend_q, pend_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  level_q, level_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  food_q, food_d;

    logic [31:0] reduce;
    logic [31:0] period;
    logic [31:0] period_m1;
    logic        key_vld;
    logic [1:0]  key_dir;
    logic        key_ok;

    assign st = status_e'(game_status);

    // Clamp before subtracting so the period never wraps below the floor
    assign reduce    = {28'd0, level_q} * STEP;
    assign period    = (reduce >= HEAD) ? MINP : BASE - reduce;
    assign period_m1 = period - 32'd1;

    always_comb begin
        key_vld = 1'b1;
        key_dir = DIR_UP;
        if (key1_press)      key_dir = DIR_UP;
        else if (key2_press) key_dir = DIR_DOWN;
        else if (key3_press) key_dir = DIR_LEFT;
        else if (key4_press) key_dir = DIR_RIGHT;
        else                 key_vld = 1'b0;
    end

    // Reversal is judged against the committed heading, not pending
    assign key_ok = key_vld && (key_dir != {dir_q[1], ~dir_q[0]});

    always_comb begin
        tick_d  = 1'b0;
        dir_d   = dir_q;
        pend_d  = pend_q;
        score_d = score_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        food_d  = food_q;
        unique case (st)
            ST_RESTART: begin
                dir_d   = DIR_RIGHT;
                pend_d  = DIR_RIGHT;
                score_d = 8'd0;
                level_d = 4'd0;
                cnt_d   = 32'd0;
                food_d  = 8'd0;
            end
            ST_START: begin
                cnt_d = 32'd0;
                if (key_ok) begin
                    pend_d = key_dir;
                    dir_d  = key_dir;
                end
            end
            ST_PLAY: begin
                if (key_ok) pend_d = key_dir;
                if (cnt_q >= period_m1) begin
                    tick_d = 1'b1;
                    cnt_d  = 32'd0;
                    dir_d  = pend_q;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (eat_food) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    if ({24'd0, food_q} + 32'd1 >= FPL) begin
                        food_d = 8'd0;
                        if (level_q < LMAX) level_d = level_q + 4'd1;
                    end else begin
                        food_d = food_q + 8'd1;
                    end
                end
            end
            ST_DIE: begin
                tick_d = 1'b0;
            end
            default: begin
                tick_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q  <= 1'b0;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            score_q <= 8'd0;
            level_q <= 4'd0;
            cnt_q   <= 32'd0;
            food_q  <= 8'd0;
        end else begin
            tick_q  <= tick_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            score_q <= score_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            food_q  <= food_d;
        end
    end

    assign move_tick = tick_q;
    assign direction = dir_q;
    assign score     = score_q;
    assign level     = level_q;

endmodule

// File: tb/tb_snake_move_sched.sv
// Directed bench for snake_move_sched with a rule-level reference model
// checked on every falling edge.
module tb_snake_move_sched;

    localparam int TB_BASE = 10;
    localparam int TB_STEP = 2;
    localparam int TB_MIN  = 4;
    localparam int TB_FPL  = 2;
    localparam int TB_LMAX = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] game_status;
    logic       key1_press, key2_press, key3_press, key4_press;
    logic       eat_food;
    logic       move_tick;
    logic [1:0] direction;
    logic [7:0] score;
    logic [3:0] level;

    int total = 0;
    int bad   = 0;

    snake_move_sched #(
        .TICK_BASE(TB_BASE),
        .TICK_STEP(TB_STEP),
        .TICK_MIN(TB_MIN),
        .FOOD_PER_LEVEL(TB_FPL),
        .LEVEL_MAX(TB_LMAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .game_status(game_status),
        .key1_press(key1_press),
        .key2_press(key2_press),
        .key3_press(key3_press),
        .key4_press(key4_press),
        .eat_food(eat_food),
        .move_tick(move_tick),
        .direction(direction),
        .score(score),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: plain integers, rules applied per clock
    bit m_on = 0;
    int m_tick, m_dir, m_pend, m_score, m_level, m_cnt, m_food;

    function automatic int per(input int lv);
        int p;
        p = TB_BASE - lv * TB_STEP;
        return (p < TB_MIN) ? TB_MIN : p;
    endfunction

    function automatic bit reverses(input int a, input int b);
        return (a / 2 == b / 2) && (a != b);
    endfunction

    always @(posedge clk) begin
        int k;
        bit kv;
        bit acc;
        bit t;
        int old_pend;
        kv = 1;
        if (key1_press)      k = 0;
        else if (key2_press) k = 1;
        else if (key3_press) k = 2;
        else if (key4_press) k = 3;
        else begin k = 0; kv = 0; end
        acc = kv && !reverses(k, m_dir);
        if (reset || game_status == 2'b00) begin
            if (reset) m_on = 1;
            m_tick = 0; m_dir = 3; m_pend = 3;
            m_score = 0; m_level = 0; m_cnt = 0; m_food = 0;
        end else if (game_status == 2'b01) begin
            m_tick = 0;
            m_cnt = 0;
            if (acc) begin m_pend = k; m_dir = k; end
        end else if (game_status == 2'b10) begin
            t = (m_cnt + 1 >= per(m_level));
            old_pend = m_pend;
            if (acc) m_pend = k;
            m_tick = t;
            if (t) begin m_cnt = 0; m_dir = old_pend; end
            else m_cnt = m_cnt + 1;
            if (eat_food) begin
                m_score = (m_score < 255) ? m_score + 1 : 255;
                m_food = (m_food + 1) % TB_FPL;
                if (m_food == 0 && m_level < TB_LMAX) m_level++;
            end
        end else begin
            m_tick = 0;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("m_tick", int'(move_tick), m_tick);
            check("m_dir", int'(direction), m_dir);
            check("m_score", int'(score), m_score);
            check("m_level", int'(level), m_level);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input logic [3:0] k);
        {key1_press, key2_press, key3_press, key4_press} = k;
        cyc(1);
        {key1_press, key2_press, key3_press, key4_press} = 4'b0000;
    endtask

    task automatic eat(input int n);
        repeat (n) begin
            eat_food = 1'b1; cyc(1);
            eat_food = 1'b0; cyc(1);
        end
    endtask

    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        do begin cyc(1); n++; end while (!move_tick && n < maxc);
        if (!move_tick) begin
            total++; bad++;
            $display("FAIL tick_timeout: no tick within %0d cycles", maxc);
        end
    endtask

    initial begin
        int n;
        int d;
        reset = 1'b1;
        game_status = 2'b00;
        {key1_press, key2_press, key3_press, key4_press} = 4'b0000;
        eat_food = 1'b0;
        cyc(3);
        reset = 1'b0;
        check("rst_tick", int'(move_tick), 0);
        check("rst_dir", int'(direction), 3);
        check("rst_score", int'(score), 0);
        check("rst_level", int'(level), 0);

        // Base period 10: ticks at PLAY cycles 10, 20, 30
        game_status = 2'b10;
        for (int i = 1; i <= 35; i++) begin
            cyc(1);
            check("tick_pos", int'(move_tick), (i % 10 == 0) ? 1 : 0);
        end
        check("dir_hold", int'(direction), 3);

        // Reverse key ignored; second turn checked against committed
        press(4'b0010);
        press(4'b1000);
        press(4'b0010);
        check("dir_pre_tick", int'(direction), 3);
        wait_tick(20, n);
        check("tick_wait", n, 2);
        check("dir_up", int'(direction), 0);
        press(4'b0010);
        check("dir_still_up", int'(direction), 0);
        wait_tick(20, n);
        check("dir_left", int'(direction), 2);
        press(4'b1001);
        wait_tick(20, n);
        check("dir_prio_up", int'(direction), 0);

        // RESTART clears, START commits key immediately
        game_status = 2'b00;
        cyc(1);
        check("rs_dir", int'(direction), 3);
        game_status = 2'b01;
        cyc(1);
        press(4'b0100);
        check("start_dir", int'(direction), 1);
        check("start_tick", int'(move_tick), 0);

        // Speed ramp
        game_status = 2'b10;
        eat(2);
        check("ramp_lvl1", int'(level), 1);
        check("ramp_sc2", int'(score), 2);
        wait_tick(20, n);
        wait_tick(20, n);
        check("space_l1", n, 8);
        eat(4);
        check("ramp_lvl3", int'(level), 3);
        check("ramp_sc6", int'(score), 6);
        wait_tick(20, n);
        wait_tick(20, n);
        check("space_l3", n, 4);
        eat(2);
        check("lvl_sat", int'(level), 3);
        check("ramp_sc8", int'(score), 8);
        wait_tick(20, n);
        wait_tick(20, n);
        check("space_floor", n, 4);

        // Score saturation
        eat_food = 1'b1;
        cyc(260);
        eat_food = 1'b0;
        cyc(1);
        check("score_sat", int'(score), 255);

        // DIE mid-period freezes everything
        wait_tick(20, n);
        cyc(1);
        game_status = 2'b11;
        cyc(1);
        d = int'(direction);
        check("die_dir", d, 1);
        eat(1);
        press(4'b0010);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("die_tick", int'(move_tick), 0);
        end
        check("die_score", int'(score), 255);
        check("die_level", int'(level), 3);
        check("die_dir_frz", int'(direction), d);

        game_status = 2'b00;
        cyc(1);
        check("clr_score", int'(score), 0);
        check("clr_level", int'(level), 0);
        check("clr_dir", int'(direction), 3);

        // Reset in the cycle before a tick suppresses it
        game_status = 2'b10;
        cyc(9);
        check("pre_rst_tick", int'(move_tick), 0);
        reset = 1'b1;
        cyc(1);
        check("rst_kill_tick", int'(move_tick), 0);
        reset = 1'b0;
        game_status = 2'b00;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_move_sched.md
# snake_move_sched

Movement scheduler for the snake datapath: generates the one-cycle `move_tick` that advances the snake, owns the committed heading `direction`, and tracks `score` and speed `level`. Sits between the game-status controller (which supplies `game_status`) and the snake body/position datapath (which consumes `move_tick`/`direction` and returns `eat_food`). The tick period shortens as food is eaten.

## Interface
- `TICK_BASE`, 12500000: tick period in clocks at level 0
- `TICK_STEP`, 1000000: period reduction per level
- `TICK_MIN`, 2500000: period floor
- `FOOD_PER_LEVEL`, 5: food items per level increment
- `LEVEL_MAX`, 9: level saturation value
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `game_status` in 2: 00 RESTART, 01 START, 10 PLAY, 11 DIE
- `key1_press`..`key4_press` in 1 each: debounced one-cycle presses: up, down, left, right
- `eat_food` in 1: one-cycle pulse from datapath, head reached food
- `move_tick` out 1: one-cycle pulse, advance snake one cell
- `direction` out 2: committed heading: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
- `score` out 8: food eaten, saturating
- `level` out 4: current speed level

## Operation
- Reset values: `move_tick`=0, `direction`=11 (RIGHT), pending=11, `score`=0, `level`=0, tick counter=0, food counter=0.
- Period = max(`TICK_BASE` − `level`·`TICK_STEP`, `TICK_MIN`), computed at 32-bit width. No underflow is permitted: clamp before subtraction goes negative.
- Key capture (START and PLAY only): highest-priority asserted key wins (key1>key2>key3>key4). It is written to pending unless it is the opposite of the committed `direction` (UP↔DOWN, LEFT↔RIGHT). The check is against committed, never pending, so two turns within one period cannot reverse the snake.
- START: tick counter held at 0, no ticks. An accepted key updates pending and `direction` in the same cycle.
- PLAY: tick counter increments each clock. When counter ≥ period−1: `move_tick`=1 next cycle, counter←0, and `direction`←pending on that tick edge.
- `eat_food` in PLAY: `score`+1 (saturates at 255). Food counter+1; when it reaches `FOOD_PER_LEVEL`, it resets to 0 and `level`+1 (saturates at `LEVEL_MAX`; the food counter still wraps). `eat_food` outside PLAY is ignored.
- DIE: counter, `direction`, `score`, `level` frozen. No ticks. Keys ignored.
- RESTART: every register returns to its reset value, held while status stays RESTART.
- `eat_food` coincident with tick: both take effect. The new period applies from the next comparison. The ≥ compare guarantees a prompt tick if the counter already exceeds the shortened period.

## Timing
- All outputs registered. `move_tick` is high exactly one cycle.
- First tick after entering PLAY: `move_tick` high in cycle N = period after the first PLAY cycle (counter 0..period−1), then every period cycles.
- `direction` updates in the same cycle `move_tick` rises, so the datapath samples both together.
- Key-to-pending latency 1 cycle. `score`/`level` update 1 cycle after `eat_food`.
- Status change is honoured the cycle after it is sampled. A PLAY→DIE transition suppresses any tick not yet registered.
- `reset` mid-operation: all outputs reach reset values on the next edge, including a `move_tick` in flight, which is forced to 0.

## Test plan
Bench parameters: `TICK_BASE`=10, `TICK_STEP`=2, `TICK_MIN`=4, `FOOD_PER_LEVEL`=2, `LEVEL_MAX`=3.
- Reset, then status PLAY with no keys → `move_tick` pulses at PLAY cycles 10, 20, 30, each exactly one cycle wide. `direction` stays 11.
- Direction RIGHT; press key3 (LEFT) → ignored. Press key1 (UP), then key3 in the same period → next tick `direction`=00. After that tick, key3 → `direction`=10 at the following tick.
- key1 and key4 pressed together → pending UP. In START, key2 → `direction`=01 immediately.
- Speed ramp: 2 `eat_food` → `level`=1, tick spacing 8; 6 total → `level`=3, spacing 4; 8 total → `level` stays 3, `score`=8.
- Saturation and ignore rules: 260 `eat_food` pulses in PLAY → `score`=255. `eat_food` during DIE → `score` unchanged.
- Freeze and clear: in PLAY, status→DIE mid-period → no ticks and outputs frozen. Status→RESTART → `score`=0, `level`=0, `direction`=11. `reset` asserted in the cycle before a tick → `move_tick` stays 0.
